// File: rtl/bakery_pkg.sv
// Shared types and helpers for the bakery mutual-exclusion model.
package bakery_pkg;

  typedef enum logic [3:0] {
    L1, L2, L3, L4, L5, L6, L7, L8, L9, L10, L11
  } loc_t;

  // Upper bounds on process count and ticket width for the generic max helper.
  localparam int MAXN = 16;
  localparam int MAXW = 16;

  // Largest ticket value representable in tkw bits.
  function automatic int tkmax_f(input int tkw);
    return (1 << tkw) - 1;
  endfunction

  // Unsigned max of the first n tickets, each packed at a MAXW-bit stride.
  function automatic logic [MAXW-1:0] tk_max_f(input logic [MAXN*MAXW-1:0] flat,
                                               input int n);
    logic [MAXW-1:0] m;
    m = '0;
    for (int i = 0; i < MAXN; i++) begin
      if (i < n && flat[i*MAXW +: MAXW] > m) m = flat[i*MAXW +: MAXW];
    end
    return m;
  endfunction

endpackage

// File: rtl/bakery_tkmax.sv
// Combinational unsigned max over a flattened ticket vector.
module bakery_tkmax
  import bakery_pkg::*;
#(
  parameter int NPROC = 3,
  parameter int TKW   = 4
) (
  input  logic [NPROC*TKW-1:0] tickets,
  output logic [TKW-1:0]       tkmax
);

  logic [MAXN*MAXW-1:0] wide;

  // Re-pack tickets at the helper's fixed stride, zero-extended.
  always_comb begin
    wide = '0;
    for (int i = 0; i < NPROC; i++) wide[i*MAXW +: TKW] = tickets[i*TKW +: TKW];
  end

  assign tkmax = TKW'(tk_max_f(wide, NPROC));

endmodule

// File: rtl/bakery_gen.sv
// Overflow-guarded bakery mutual-exclusion model, one process stepped per clock.
// Optional macro BAKERY_MUTEX_CHECK_EN adds the sticky mutex_err monitor.
//
// state | meaning
// L1    | set choosing
// L2    | take ticket = max+1, held here while max is saturated
// L3    | clear choosing
// L4    | j = 0
// L5    | loop test: more processes to scan, else enter
// L6    | wait while process j is choosing
// L7    | wait while process j has priority
// L8    | j = j + 1
// L9    | critical section
// L10   | release ticket
// L11   | remainder section
module bakery_gen
  import bakery_pkg::*;
#(
  parameter int NPROC = 3,
  parameter int TKW   = 4,
  parameter int SELW  = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [SELW-1:0]  select,
  input  logic             pause,
  output logic [SELW-1:0]  sel_q,
  output logic [NPROC-1:0] crit,
  output logic             wrap_stall,
  output logic             mutex_err
);

  localparam logic [TKW-1:0] TKMAX = TKW'(tkmax_f(TKW));

  loc_t            pc       [NPROC];
  logic [TKW-1:0]  ticket   [NPROC];
  logic [SELW-1:0] j        [NPROC];
  logic [NPROC-1:0] choosing;

  logic [SELW-1:0]      sel_c, k;
  loc_t                 pc_s, pc_nx;
  logic [TKW-1:0]       tk_s, tk_nx, tk_k, tk_max;
  logic [SELW-1:0]      j_s, j_nx;
  logic                 ch_s, ch_nx, ch_k, stall_nx;
  logic [NPROC*TKW-1:0] tk_flat;

  bakery_tkmax #(.NPROC(NPROC), .TKW(TKW)) u_tkmax (
    .tickets (tk_flat),
    .tkmax   (tk_max)
  );

  // Gather the stepped process's state and the state of its scan target k = j.
  always_comb begin
    sel_c   = (select >= SELW'(NPROC)) ? '0 : select;
    pc_s    = L1;
    tk_s    = '0;
    j_s     = '0;
    ch_s    = 1'b0;
    tk_k    = '0;
    ch_k    = 1'b0;
    tk_flat = '0;
    for (int p = 0; p < NPROC; p++) begin
      tk_flat[p*TKW +: TKW] = ticket[p];
      if (SELW'(p) == sel_c) begin
        pc_s = pc[p];
        tk_s = ticket[p];
        j_s  = j[p];
        ch_s = choosing[p];
      end
    end
    k = j_s;
    for (int i = 0; i < NPROC; i++) begin
      if (SELW'(i) == k) begin
        tk_k = ticket[i];
        ch_k = choosing[i];
      end
    end
  end

  // Next state of the stepped process.
  always_comb begin
    pc_nx    = pc_s;
    tk_nx    = tk_s;
    j_nx     = j_s;
    ch_nx    = ch_s;
    stall_nx = 1'b0;
    case (pc_s)
      L1:  begin ch_nx = 1'b1; pc_nx = L2; end
      L2: begin
        if (tk_max == TKMAX) stall_nx = 1'b1;
        else begin
          tk_nx = tk_max + 1'b1;
          pc_nx = L3;
        end
      end
      L3:  begin ch_nx = 1'b0; pc_nx = L4; end
      L4:  begin j_nx = '0; pc_nx = L5; end
      L5:  pc_nx = (j_s <= SELW'(NPROC-1)) ? L6 : L9;
      L6:  if (!ch_k) pc_nx = L7;
      L7:  if (!((tk_k != '0) && ((tk_k < tk_s) || ((tk_k == tk_s) && (k < sel_c)))))
             pc_nx = L8;
      L8:  begin j_nx = j_s + 1'b1; pc_nx = L5; end
      L9:  if (!pause) pc_nx = L10;
      L10: begin tk_nx = '0; pc_nx = L11; end
      L11: if (!pause) pc_nx = L1;
      default: pc_nx = L1;
    endcase
  end

  // State register: only the selected process is updated.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int p = 0; p < NPROC; p++) begin
        pc[p]     <= L1;
        ticket[p] <= '0;
        j[p]      <= '0;
      end
      choosing   <= '0;
      sel_q      <= '0;
      wrap_stall <= 1'b0;
    end else begin
      for (int p = 0; p < NPROC; p++) begin
        if (SELW'(p) == sel_c) begin
          pc[p]       <= pc_nx;
          ticket[p]   <= tk_nx;
          j[p]        <= j_nx;
          choosing[p] <= ch_nx;
        end
      end
      sel_q      <= sel_c;
      wrap_stall <= stall_nx;
    end
  end

  // Critical-section occupancy decoded from registered pc.
  always_comb begin
    for (int p = 0; p < NPROC; p++) crit[p] = (pc[p] == L9);
  end

`ifdef BAKERY_MUTEX_CHECK_EN
  // Sticky flag: two or more processes ever seen in the critical section.
  always_ff @(posedge clock) begin
    if (reset) mutex_err <= 1'b0;
    else if ($countones(crit) > 1) mutex_err <= 1'b1;
  end
`else
  assign mutex_err = 1'b0;
`endif

endmodule
